dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
Data-memory bridge directly downstream of the single-cycle datapath. It consumes ALUResult (address), WriteData and the MemWrite/MemRead/MemByte strobes, and returns ReadData. It runs a multi-cycle request/acknowledge transaction on an external memory bus, stalling the core until completion. It also handles byte-lane steering for LDRB/STRB and flags misaligned word accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max bus wait cycles in REQ before abort (must be >=2)
AW, 32, address width
DW, 32, data width (fixed 32 for lane logic)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-low (0 = reset), sampled on clk rising edge
MemRead  in  1  load request (held stable while Stall=1)
MemWrite  in  1  store request (held stable while Stall=1)
MemByte  in  1  1 = byte access, 0 = word access
Adr  in  AW  byte address (datapath ALUResult)
WriteData  in  DW  store data
ReadData  out  DW  load data, valid in DONE cycle
Stall  out  1  freeze PC/regfile write while 1
Fault  out  1  one-cycle pulse: misaligned or timeout
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write
bus_addr  out  AW  word-aligned address ({Adr[31:2],2'b00})
bus_wdata  out  DW  lane-steered write data
bus_be  out  4  byte enables
bus_ack  in  1  bus completion, single-cycle pulse
bus_rdata  in  DW  read data, valid with bus_ack

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset -> IDLE; ReadData=0, Fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, timeout counter=0.
- Request = MemRead | MemWrite. MemRead & MemWrite both 1: treated as write.
- Stall = Request & (state != DONE); combinational, so the request cycle itself stalls.
- IDLE: request & aligned -> REQ, latch addr/we/wdata/be into bus_* registers. Word access with Adr[1:0]!=0 -> DONE directly with Fault=1, no bus_req, ReadData=0.
- REQ: bus_req=1, bus_* held constant. bus_ack=1 -> DONE, latch ReadData. Counter increments each REQ cycle; counter reaches TIMEOUT-1 without ack -> DONE, Fault=1, ReadData=0, bus_req drops. Ack on the timeout cycle wins (normal completion, no Fault).
- DONE: exactly one cycle, Stall=0, bus_req=0, ReadData/Fault valid; -> IDLE unconditionally. Fault is high only in DONE.
- Minimum latency: request at cycle 0, bus_req cycles 1..k, ack at k, DONE at k+1; stall = k+1 cycles.
- Byte write: bus_wdata = WriteData[7:0] replicated in all 4 lanes; bus_be = one-hot (1<<Adr[1:0]). Word write: bus_wdata=WriteData, bus_be=4'b1111. Reads: bus_be per same rule.
- Byte read: ReadData = zero-extended lane bus_rdata[8*Adr[1:0]+7 -: 8]. Word read: ReadData = bus_rdata.
- ReadData holds its value outside DONE until the next completion.
- bus_ack outside REQ is ignored.
- Reset asserted mid-REQ: next edge forces IDLE, bus_req=0; the aborted transaction is never reissued.
- No request in IDLE: Stall=0, no bus activity.

Test Plan:
- Word load Adr=0x100, bus_ack 2 cycles after bus_req, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, Stall high 3 cycles, ReadData=0xDEADBEEF in DONE, Fault=0.
- STRB Adr=0x203, WriteData=0x12345678 -> bus_addr=0x200, bus_be=1000, bus_wdata=0x78787878, bus_we=1.
- LDRB Adr=0x102, bus_rdata=0xAABBCCDD -> ReadData=0x000000BB.
- Word load Adr=0x102 -> no bus_req, Fault pulse 1 cycle, ReadData=0, Stall released after 1 cycle.
- Store with bus_ack never asserted, TIMEOUT=16 -> bus_req high 16 cycles, Fault pulse in DONE, FSM back to IDLE.
- reset=0 on cycle 2 of REQ -> next edge bus_req=0, Stall=0 (no request), all outputs at reset values; spurious bus_ack afterwards ignored.

Source files
------------

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Purpose:
//   Data-memory bridge that sits directly after the single-cycle datapath.
//   A load/store strobe from the core becomes a request/acknowledge
//   transaction on an external memory bus. The core is stalled until the
//   transaction completes. The bridge steers byte lanes for LDRB/STRB and
//   raises a one-cycle Fault for misaligned word accesses and for bus
//   timeouts.
//
// Ports:
//   clk        in   core clock, rising edge
//   reset      in   synchronous, active-low reset (0 = reset)
//   MemRead    in   load request, held stable while Stall=1
//   MemWrite   in   store request, held stable while Stall=1 (wins over MemRead)
//   MemByte    in   1 = byte access, 0 = word access
//   Adr        in   byte address from the datapath ALU
//   WriteData  in   store data
//   ReadData   out  load data, valid in the completion (DONE) cycle, then held
//   Stall      out  freezes PC/regfile write while high
//   Fault      out  one-cycle pulse in DONE on misalignment or bus timeout
//   bus_req    out  bus request, held until bus_ack or timeout
//   bus_we     out  1 = bus write
//   bus_addr   out  word-aligned bus address
//   bus_wdata  out  lane-steered write data
//   bus_be     out  byte enables
//   bus_ack    in   single-cycle completion pulse from the bus
//   bus_rdata  in   bus read data, valid with bus_ack
// -----------------------------------------------------------------------------
module dmem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          MemByte,
    input  logic [AW-1:0] Adr,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic          Fault,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [3:0]    bus_be,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic [CW-1:0]  r_count;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [3:0]     r_be;
    logic [1:0]     r_lane;
    logic           r_byte;
    logic [DW-1:0]  r_readData;
    logic           r_fault;

    logic           w_request;
    logic           w_misaligned;
    logic           w_timeout;
    logic           w_start;
    logic           w_latchRead;
    logic           w_faultSet;
    logic [7:0]     w_laneByte;
    logic [DW-1:0]  w_steeredRead;

    assign w_request    = MemRead | MemWrite;
    assign w_misaligned = !MemByte && (Adr[1:0] != 2'b00);
    assign w_timeout    = (r_count == CW'(TIMEOUT - 1));

    // State register. Reset drops any in-flight transaction; it is never
    // reissued because the core re-presents requests only after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. A misaligned word access skips the bus
    // entirely and goes straight to DONE with a fault. In REQ an ack always
    // beats the timeout, even when both land on the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_latchRead = 1'b0;
        w_faultSet  = 1'b0;
        Stall       = 1'b0;
        bus_req     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    Stall = 1'b1;
                    if (w_misaligned) begin
                        w_nextState = S_DONE;
                        w_faultSet  = 1'b1;
                    end else begin
                        w_nextState = S_REQ;
                        w_start     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                Stall   = w_request;
                bus_req = 1'b1;
                if (bus_ack) begin
                    w_nextState = S_DONE;
                    w_latchRead = !r_we;
                end else if (w_timeout) begin
                    w_nextState = S_DONE;
                    w_faultSet  = 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Select the addressed byte of the returned bus word for byte loads.
    always_comb begin
        w_laneByte = 8'h00;
        case (r_lane)
            2'd0:    w_laneByte = bus_rdata[7:0];
            2'd1:    w_laneByte = bus_rdata[15:8];
            2'd2:    w_laneByte = bus_rdata[23:16];
            default: w_laneByte = bus_rdata[31:24];
        endcase
    end

    assign w_steeredRead = r_byte ? {{(DW-8){1'b0}}, w_laneByte} : bus_rdata;

    // Bus-side registers and result capture. The bus fields are captured once
    // when the request is accepted, so they stay constant for the whole REQ
    // phase even if the datapath inputs wiggle. ReadData only changes on a
    // completed load or on a fault, and holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_lane     <= 2'b00;
            r_byte     <= 1'b0;
            r_readData <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_start) begin
                r_we   <= MemWrite;
                r_addr <= {Adr[AW-1:2], 2'b00};
                r_lane <= Adr[1:0];
                r_byte <= MemByte;
                if (MemByte) begin
                    r_wdata <= {4{WriteData[7:0]}};
                    r_be    <= 4'b0001 << Adr[1:0];
                end else begin
                    r_wdata <= WriteData;
                    r_be    <= 4'b1111;
                end
            end

            if (r_state == S_REQ) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end

            if (w_latchRead) begin
                r_readData <= w_steeredRead;
            end else if (w_faultSet) begin
                r_readData <= '0;
            end

            r_fault <= w_faultSet;
        end
    end

    assign ReadData  = r_readData;
    assign Fault     = r_fault;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Self-checking bench for dmem_bridge. Each transaction's expected result is
// computed from the bridge's behavioural rules and queued when the request is
// issued. An independent monitor compares bus-side fields every bus_req cycle
// and pops/compares the completion result whenever the bridge releases a
// held request (request high, Stall low).
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        MemByte;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] readData;
        logic        fault;
        logic        checkRead;
        int          stallCycles;
        int          reqCycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t expQ[$];

    int   compareCount = 0;
    int   failCount    = 0;
    logic monitorOn    = 1'b0;

    dmem_bridge #(
        .TIMEOUT(TIMEOUT),
        .AW(32),
        .DW(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .MemByte(MemByte),
        .Adr(Adr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Stall(Stall),
        .Fault(Fault),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be(bus_be),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global guard so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: derive what the bridge must do for one access, then
    // drive the access and act as the bus slave until the core is released.
    task automatic applyStimulus(input logic rd, input logic wr, input logic byteAcc,
                                 input logic [31:0] adr, input logic [31:0] wd,
                                 input logic [31:0] rdat, input int ackAt);
        exp_t e;
        int   lane;
        int   n;
        int   guard;
        bit   finished;
        lane    = int'(adr[1:0]);
        e.we    = wr;
        e.addr  = adr & 32'hFFFF_FFFC;
        e.be    = byteAcc ? 4'(1 << lane) : 4'hF;
        e.wdata = byteAcc ? {4{wd[7:0]}} : wd;
        if (!byteAcc && lane != 0) begin
            e.fault = 1'b1; e.readData = 32'h0; e.checkRead = 1'b1;
            e.stallCycles = 1; e.reqCycles = 0;
        end else if (ackAt < 1 || ackAt > TIMEOUT) begin
            e.fault = 1'b1; e.readData = 32'h0; e.checkRead = 1'b1;
            e.stallCycles = TIMEOUT + 1; e.reqCycles = TIMEOUT;
        end else begin
            e.fault = 1'b0;
            e.readData = byteAcc ? ((rdat >> (8 * lane)) & 32'hFF) : rdat;
            e.checkRead = !wr;
            e.stallCycles = ackAt + 1; e.reqCycles = ackAt;
        end

        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; MemByte = byteAcc; Adr = adr; WriteData = wd;
        expQ.push_back(e);

        n = 0; guard = 0; finished = 0;
        while (!finished) begin
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (!Stall) begin
                finished = 1;
            end else if (guard > 100) begin
                checkOutput("txn_hang", 64'(guard), 64'd0);
                finished = 1;
            end else begin
                guard++;
                if (bus_req) begin
                    n++;
                    if (n == ackAt) begin
                        bus_ack   = 1'b1;
                        bus_rdata = rdat;
                    end
                end
            end
        end

        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
        if (guard > 100) begin
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            expQ.delete();
        end
    endtask

    // Monitor: bus fields every request cycle, results on completion.
    int   stallCount = 0;
    int   reqCount   = 0;
    exp_t monE;
    logic isDone;

    always @(negedge clk) begin
        if (!monitorOn || !reset) begin
            stallCount = 0;
            reqCount   = 0;
        end else begin
            isDone = (MemRead | MemWrite) && !Stall;
            if (Stall) stallCount++;
            if (bus_req) begin
                reqCount++;
                if (expQ.size() == 0) begin
                    checkOutput("bus_req_unexpected", 64'd1, 64'd0);
                end else begin
                    monE = expQ[0];
                    checkOutput("bus_we", 64'(bus_we), 64'(monE.we));
                    checkOutput("bus_addr", 64'(bus_addr), 64'(monE.addr));
                    checkOutput("bus_wdata", 64'(bus_wdata), 64'(monE.wdata));
                    checkOutput("bus_be", 64'(bus_be), 64'(monE.be));
                end
            end
            if (Fault && !isDone) checkOutput("fault_stray", 64'd1, 64'd0);
            if (isDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("done_unexpected", 64'd1, 64'd0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("fault", 64'(Fault), 64'(monE.fault));
                    checkOutput("stall_cycles", 64'(stallCount), 64'(monE.stallCycles));
                    checkOutput("req_cycles", 64'(reqCount), 64'(monE.reqCycles));
                    if (monE.checkRead) begin
                        checkOutput("read_data", 64'(ReadData), 64'(monE.readData));
                    end
                end
                stallCount = 0;
                reqCount   = 0;
            end
        end
    end

    // Checks that every output sits at its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ReadData"}, 64'(ReadData), 64'd0);
        checkOutput({tag, "_Fault"}, 64'(Fault), 64'd0);
        checkOutput({tag, "_Stall"}, 64'(Stall), 64'd0);
        checkOutput({tag, "_bus_req"}, 64'(bus_req), 64'd0);
        checkOutput({tag, "_bus_we"}, 64'(bus_we), 64'd0);
        checkOutput({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
        checkOutput({tag, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
        checkOutput({tag, "_bus_be"}, 64'(bus_be), 64'd0);
    endtask

    // Reset asserted during the second REQ cycle of a store that is never acked.
    task automatic resetMidRequest();
        int n;
        int guard;
        @(posedge clk); #1;
        monitorOn = 1'b0;
        MemWrite = 1'b1; MemRead = 1'b0; MemByte = 1'b0;
        Adr = 32'h0000_0300; WriteData = 32'hCAFE_F00D;
        n = 0; guard = 0;
        while (n < 2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
            if (bus_req) n++;
        end
        checkOutput("midreq_reached", 64'(n), 64'd2);
        reset = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkResetValues("midreq_reset");
        @(posedge clk); #1;
        reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        checkOutput("spurious_ack_bus_req", 64'(bus_req), 64'd0);
        checkOutput("spurious_ack_Stall", 64'(Stall), 64'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_bus_req", 64'(bus_req), 64'd0);
            checkOutput("post_reset_Fault", 64'(Fault), 64'd0);
            checkOutput("post_reset_ReadData", 64'(ReadData), 64'd0);
        end
        @(posedge clk); #1;
        monitorOn = 1'b1;
    endtask

    initial begin
        int r;
        int ackAt;
        int op;
        int guard;
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0;
        Adr = '0; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        monitorOn = 1'b1;

        // Directed accesses.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 32'h0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'hAABB_CCDD, 3);
        resetMidRequest();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h5555_5555, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0BAD_F00D, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'h7654_3210, TIMEOUT);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0601, 32'hFFFF_FF9A, 32'h0, 1);

        // Randomized accesses.
        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 9));
            ackAt = (r == 0) ? 0 : ((r == 9) ? TIMEOUT : r);
            op = int'($urandom_range(0, 2));
            applyStimulus(op != 1, op != 0, 1'($urandom_range(0, 1)), $urandom,
                          $urandom, $urandom, ackAt);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        guard = 0;
        while (expQ.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
